// File: rtl/hs_pkg.sv
// -----------------------------------------------------------------------------
// hs_pkg -- shared definitions for the four-phase handshake transmitter.
//   * hs_state_t : transmit FSM states (IDLE, SEND, RELEASE)
//   * DEF_*      : default parameter values used by hs_fifo and cpu_hs_tx
// No ports (package).
// -----------------------------------------------------------------------------
package hs_pkg;

    localparam int DEF_DATA_WIDTH     = 4;
    localparam int DEF_FIFO_DEPTH     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } hs_state_t;

endpackage

// File: rtl/hs_fifo.sv
// -----------------------------------------------------------------------------
// hs_fifo -- synchronous first-in first-out buffer feeding the transmit FSM.
// Ports:
//   clock    in   single clock, rising edge
//   reset    in   synchronous active-high reset (clears pointers and count)
//   wr_valid in   write request
//   wr_data  in   word to enqueue
//   wr_ready out  high while not full
//   pop      in   remove the head word (ignored when empty)
//   rd_data  out  head word (valid when count > 0)
//   count    out  occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module hs_fifo
    import hs_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wr_valid,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          wr_ready,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("hs_fifo: FIFO_DEPTH must be a power of two and at least 2");
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  push;
    logic                  pop_ok;

    // A write while full is dropped even if a pop frees a slot at the same
    // edge, so acceptance depends only on the current occupancy.
    assign wr_ready = (count != CNT_W'(FIFO_DEPTH));
    assign push     = wr_valid && wr_ready;
    assign pop_ok   = pop && (count != '0);
    assign rd_data  = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and count need a
    // known value, and a resettable array would cost a flop reset per bit.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly log2(FIFO_DEPTH) bits, so they wrap for free.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_hs_tx.sv
// -----------------------------------------------------------------------------
// cpu_hs_tx -- buffered four-phase handshake transmitter.
// Words written by the producer are queued in hs_fifo and presented one at a
// time on tx_dados/tx_send; each word is held until the peripheral raises
// tx_ack, and the next word waits until tx_ack has fallen again.
// Ports:
//   tx_clock     in   single clock, rising edge
//   tx_reset     in   synchronous active-high reset
//   tx_wr_valid  in   producer write request
//   tx_wr_data   in   word to enqueue
//   tx_wr_ready  out  high while the FIFO is not full
//   tx_send      out  high while a word is on the bus
//   tx_dados     out  bus data (keeps the last word after release)
//   tx_ack       in   peripheral receipt acknowledge
//   tx_count     out  FIFO occupancy
//   tx_timeout   out  sticky ack-timeout flag
// Build option: define HS_TX_TIMEOUT_EN to abandon a word after
// TIMEOUT_CYCLES SEND cycles without ack; otherwise tx_timeout is tied low
// and SEND waits indefinitely.
// -----------------------------------------------------------------------------
module cpu_hs_tx
    import hs_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          tx_clock,
    input  logic                          tx_reset,
    input  logic                          tx_wr_valid,
    input  logic [DATA_WIDTH-1:0]         tx_wr_data,
    output logic                          tx_wr_ready,
    output logic                          tx_send,
    output logic [DATA_WIDTH-1:0]         tx_dados,
    input  logic                          tx_ack,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count,
    output logic                          tx_timeout
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cpu_hs_tx: TIMEOUT_CYCLES must be at least 1");
    end

    hs_state_t             state;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  pop;
    logic                  timer_hit;

    // The head word is consumed at the same edge that loads it onto the bus.
    // A held-high ack blocks the next transfer until the peripheral releases.
    assign pop = (state == IDLE) && (tx_count != '0) && !tx_ack;

    hs_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (tx_clock),
        .reset    (tx_reset),
        .wr_valid (tx_wr_valid),
        .wr_data  (tx_wr_data),
        .wr_ready (tx_wr_ready),
        .pop      (pop),
        .rd_data  (head_data),
        .count    (tx_count)
    );

`ifdef HS_TX_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] timer;
    logic             timeout_flag;

    // Fires on the TIMEOUT_CYCLES-th SEND edge without ack, so tx_send is
    // high for exactly TIMEOUT_CYCLES cycles before the word is abandoned.
    assign timer_hit = (state == SEND) && !tx_ack &&
                       (timer == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge tx_clock) begin
        if (tx_reset || state != SEND) begin
            timer <= '0;
        end else if (!tx_ack) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge tx_clock) begin
        if (tx_reset) begin
            timeout_flag <= 1'b0;
        end else if (timer_hit) begin
            timeout_flag <= 1'b1;
        end
    end

    assign tx_timeout = timeout_flag;
`else
    assign timer_hit  = 1'b0;
    assign tx_timeout = 1'b0;
`endif

    // NOTE: all FSM state and bus outputs are registered with non-blocking
    // assignments so every output changes only at the clock edge.
    always_ff @(posedge tx_clock) begin
        if (tx_reset) begin
            state    <= IDLE;
            tx_send  <= 1'b0;
            tx_dados <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_dados <= head_data;
                        tx_send  <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ack) begin
                        tx_send <= 1'b0;
                        state   <= RELEASE;
                    end else if (timer_hit) begin
                        tx_send <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RELEASE: begin
                    if (!tx_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_send <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_hs_tx.sv
// -----------------------------------------------------------------------------
// tb_cpu_hs_tx -- self-checking bench for cpu_hs_tx (DATA_WIDTH=4,
// FIFO_DEPTH=8, TIMEOUT_CYCLES=16). Expected words come from a queue of
// accepted writes; timing expectations come from the handshake rules.
// The timeout scenario follows HS_TX_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_cpu_hs_tx;

    localparam int DW    = 4;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic          tx_clock;
    logic          tx_reset;
    logic          tx_wr_valid;
    logic [DW-1:0] tx_wr_data;
    logic          tx_wr_ready;
    logic          tx_send;
    logic [DW-1:0] tx_dados;
    logic          tx_ack;
    logic [3:0]    tx_count;
    logic          tx_timeout;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q[$];

    cpu_hs_tx #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .tx_clock    (tx_clock),
        .tx_reset    (tx_reset),
        .tx_wr_valid (tx_wr_valid),
        .tx_wr_data  (tx_wr_data),
        .tx_wr_ready (tx_wr_ready),
        .tx_send     (tx_send),
        .tx_dados    (tx_dados),
        .tx_ack      (tx_ack),
        .tx_count    (tx_count),
        .tx_timeout  (tx_timeout)
    );

    initial tx_clock = 1'b0;
    always #5 tx_clock = ~tx_clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1);
    end

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge tx_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        tx_wr_valid = 1'b1;
        tx_wr_data  = d;
        tick();
        tx_wr_valid = 1'b0;
    endtask

    // Responder: wait (bounded) for tx_send, check the word, ack for one
    // cycle, then release so the FSM returns to IDLE.
    task automatic receive(input string tag, input logic [DW-1:0] expd);
        int waited;
        waited = 0;
        while (tx_send !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "_send"}, {31'd0, tx_send}, 32'd1);
        check({tag, "_data"}, {28'd0, tx_dados}, {28'd0, expd});
        tx_ack = 1'b1;
        tick();
        check({tag, "_drop"}, {31'd0, tx_send}, 32'd0);
        tx_ack = 1'b0;
        tick();
    endtask

    initial begin
        logic [DW-1:0] w1;
        logic [DW-1:0] w2;
        int            k;

        tx_reset    = 1'b1;
        tx_wr_valid = 1'b0;
        tx_wr_data  = '0;
        tx_ack      = 1'b0;
        tick();
        tick();
        tx_reset = 1'b0;

        // Reset state
        check("rst_send",    {31'd0, tx_send},     32'd0);
        check("rst_dados",   {28'd0, tx_dados},    32'd0);
        check("rst_count",   {28'd0, tx_count},    32'd0);
        check("rst_ready",   {31'd0, tx_wr_ready}, 32'd1);
        check("rst_timeout", {31'd0, tx_timeout},  32'd0);

        // Single transfer of 4'hA, ack one cycle after send rises
        write_word(4'hA);
        check("single_cnt1",  {28'd0, tx_count}, 32'd1);
        check("single_nosend", {31'd0, tx_send}, 32'd0);
        tick();
        check("single_send1", {31'd0, tx_send},  32'd1);
        check("single_data",  {28'd0, tx_dados}, 32'hA);
        check("single_cnt0",  {28'd0, tx_count}, 32'd0);
        tick();
        check("single_send2", {31'd0, tx_send},  32'd1);
        tx_ack = 1'b1;
        tick();
        check("single_fall",  {31'd0, tx_send},  32'd0);
        check("single_keep",  {28'd0, tx_dados}, 32'hA);
        tx_ack = 1'b0;
        tick();
        check("single_idle",  {31'd0, tx_send},  32'd0);

        // Fill: ack held high keeps the FSM in IDLE so all 8 words stay queued
        tx_ack = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            write_word(DW'(i));
            exp_q.push_back(DW'(i));
        end
        check("full_count", {28'd0, tx_count},    32'd8);
        check("full_ready", {31'd0, tx_wr_ready}, 32'd0);
        check("full_block", {31'd0, tx_send},     32'd0);
        // Ninth write lands on the same edge as the first pop: it must be dropped
        tx_ack      = 1'b0;
        tx_wr_valid = 1'b1;
        tx_wr_data  = 4'h8;
        tick();
        tx_wr_valid = 1'b0;
        check("full_drop_cnt", {28'd0, tx_count}, 32'd7);
        while (exp_q.size() > 0) begin
            receive("order", exp_q.pop_front());
        end
        check("order_empty", {28'd0, tx_count}, 32'd0);
        tick();
        tick();
        check("order_nodup", {31'd0, tx_send}, 32'd0);

        // Held ack: RELEASE persists while ack stays high
        w1 = DW'($urandom);
        w2 = DW'($urandom);
        write_word(w1);
        tick();
        check("held_send", {31'd0, tx_send},  32'd1);
        check("held_w1",   {28'd0, tx_dados}, {28'd0, w1});
        tx_ack = 1'b1;
        tick();
        check("held_fall", {31'd0, tx_send}, 32'd0);
        write_word(w2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_block", {31'd0, tx_send}, 32'd0);
        end
        check("held_cnt", {28'd0, tx_count}, 32'd1);
        tx_ack = 1'b0;
        tick();
        check("held_rel", {31'd0, tx_send}, 32'd0);
        tick();
        check("held_next", {31'd0, tx_send},  32'd1);
        check("held_w2",   {28'd0, tx_dados}, {28'd0, w2});
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        tick();

        // Reset during SEND with 3 words queued; reset beats write and ack
        for (int i = 0; i < 4; i++) begin
            write_word(DW'($urandom_range(1, 15)));
        end
        check("rmid_send", {31'd0, tx_send},  32'd1);
        check("rmid_cnt",  {28'd0, tx_count}, 32'd3);
        tx_reset    = 1'b1;
        tx_wr_valid = 1'b1;
        tx_wr_data  = 4'h5;
        tx_ack      = 1'b1;
        tick();
        tx_reset    = 1'b0;
        tx_wr_valid = 1'b0;
        tx_ack      = 1'b0;
        check("rmid_send0",  {31'd0, tx_send},  32'd0);
        check("rmid_dados0", {28'd0, tx_dados}, 32'd0);
        check("rmid_cnt0",   {28'd0, tx_count}, 32'd0);
        tick();
        tick();
        check("rmid_quiet", {31'd0, tx_send}, 32'd0);

        // Ack never arrives for the first of two queued words
        w1 = DW'($urandom);
        w2 = DW'($urandom);
        write_word(w1);
        write_word(w2);
        check("tmo_send", {31'd0, tx_send},  32'd1);
        check("tmo_w1",   {28'd0, tx_dados}, {28'd0, w1});
`ifdef HS_TX_TIMEOUT_EN
        for (int i = 1; i < TMO; i++) begin
            tick();
            check("tmo_hold", {31'd0, tx_send}, 32'd1);
        end
        tick();
        check("tmo_fall", {31'd0, tx_send},    32'd0);
        check("tmo_flag", {31'd0, tx_timeout}, 32'd1);
        tick();
        check("tmo_next",   {31'd0, tx_send},    32'd1);
        check("tmo_w2",     {28'd0, tx_dados},   {28'd0, w2});
        check("tmo_sticky", {31'd0, tx_timeout}, 32'd1);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        tick();
        check("tmo_sticky2", {31'd0, tx_timeout}, 32'd1);
        tx_reset = 1'b1;
        tick();
        tx_reset = 1'b0;
        check("tmo_clear", {31'd0, tx_timeout}, 32'd0);
`else
        for (int i = 0; i < TMO + 4; i++) begin
            tick();
            check("wait_hold", {27'd0, tx_timeout, tx_send, tx_dados}, {27'd0, 1'b0, 1'b1, w1});
        end
        receive("wait_w1", w1);
        receive("wait_w2", w2);
`endif

        // Pointer wrap: 20 single write/transfer pairs
        for (int i = 0; i < 20; i++) begin
            w1 = DW'($urandom);
            write_word(w1);
            exp_q.push_back(w1);
            receive("wrap", exp_q.pop_front());
        end
        check("wrap_empty", {28'd0, tx_count}, 32'd0);

        // Random bursts: first word leaves for the bus at the second edge
        for (int b = 0; b < 10; b++) begin
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) begin
                w1 = DW'($urandom);
                write_word(w1);
                exp_q.push_back(w1);
            end
            check("burst_cnt", {28'd0, tx_count}, (k == 1) ? 32'd1 : 32'(k - 1));
            while (exp_q.size() > 0) begin
                receive("burst", exp_q.pop_front());
            end
            check("burst_empty", {28'd0, tx_count}, 32'd0);
`ifndef HS_TX_TIMEOUT_EN
            check("burst_tmo", {31'd0, tx_timeout}, 32'd0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_hs_tx.md
CPU_HS_TX -- requirements
Module: cpu_hs_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, the width in bits of each transferred word.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, the number of buffered words; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 16, the ack-wait limit used only when HS_TX_TIMEOUT_EN is defined.
REQ-004 The block SHALL have port tx_clock, input, width 1: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port tx_reset, input, width 1: synchronous, active-high reset.
REQ-006 The block SHALL have port tx_wr_valid, input, width 1: a write request from the producer.
REQ-007 The block SHALL have port tx_wr_data, input, width DATA_WIDTH: the word to enqueue.
REQ-008 The block SHALL have port tx_wr_ready, output, width 1: high when the FIFO is not full.
REQ-009 The block SHALL have port tx_send, output, width 1: high when a word is on the bus.
REQ-010 The block SHALL have port tx_dados, output, width DATA_WIDTH: the bus data.
REQ-011 The block SHALL have port tx_ack, input, width 1: the peripheral's receipt acknowledge.
REQ-012 The block SHALL have port tx_count, output, width log2(FIFO_DEPTH)+1: the current FIFO occupancy.
REQ-013 The block SHALL have port tx_timeout, output, width 1: sticky error flag.

Function
REQ-014 A write SHALL be accepted at a rising edge where tx_wr_valid=1 and tx_wr_ready=1; a write while full SHALL be ignored, even if a pop occurs in the same cycle.
REQ-015 The FIFO SHALL be first-in first-out, with read and write pointers wrapping modulo FIFO_DEPTH and tx_count ranging from 0 to FIFO_DEPTH.
REQ-016 A simultaneous accepted write and pop SHALL leave tx_count unchanged.
REQ-017 The FSM SHALL have three states: IDLE, SEND and RELEASE; reset state IDLE.
REQ-018 In IDLE with tx_count>0 and tx_ack=0, the FSM SHALL pop the head word into the tx_dados register, set tx_send=1 and go to SEND at the same edge.
REQ-019 A write into an empty FIFO at edge N SHALL produce tx_send=1 after edge N+1, which is a two-edge latency.
REQ-020 In SEND, tx_dados and tx_send SHALL hold stable until tx_ack=1 is sampled; then tx_send SHALL be 0 and the FSM SHALL go to RELEASE.
REQ-021 In RELEASE, the FSM SHALL wait for tx_ack=0, then go to IDLE; tx_dados SHALL keep its last value.
REQ-022 In IDLE, a tx_ack held at 1 SHALL block the next transfer (four-phase protocol).
REQ-023 Steady-state throughput SHALL be at most one word per 4 cycles with an ack that responds in one cycle.

Reset
REQ-024 At an edge with tx_reset=1, the block SHALL force tx_send=0, tx_dados=0, tx_count=0, both pointers to 0, state IDLE and tx_timeout=0.
REQ-025 Reset SHALL take priority over write, pop and ack at the same edge.
REQ-026 Reset during SEND SHALL discard the in-flight word and all buffered words.

Configuration
REQ-027 With macro HS_TX_TIMEOUT_EN defined, a counter SHALL count SEND cycles with tx_ack=0.
REQ-028 With HS_TX_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES the block SHALL set tx_send=0, drop the word, set tx_timeout=1 and go to IDLE.
REQ-029 With HS_TX_TIMEOUT_EN defined, tx_timeout SHALL clear only on reset, and transfers SHALL continue while it is set.
REQ-030 Without HS_TX_TIMEOUT_EN, tx_timeout SHALL be constant 0, no counter logic SHALL exist, and SEND SHALL wait indefinitely.

Structure
REQ-031 Package hs_pkg SHALL hold the FSM state enum (IDLE, SEND, RELEASE) and the default parameter constants.
REQ-032 The FIFO storage, pointers and occupancy logic SHALL be one sub-module, hs_fifo, parametrised by DATA_WIDTH and FIFO_DEPTH; the FSM SHALL reside in cpu_hs_tx.

Verification
REQ-033 Single transfer: write 4'hA while idle, then ack one cycle after send rises -> tx_send high for exactly 2 cycles, tx_dados=4'hA, tx_count 1->0.
REQ-034 Ordering and full: write 0..7 back-to-back with ack withheld -> tx_wr_ready=0 after the eighth accept, a ninth write is ignored, and words then emerge in order 0..7 under the responder.
REQ-035 Held ack: hold tx_ack=1 for 5 cycles after a transfer -> the FSM stays in RELEASE, and the next tx_send rises only after ack falls.
REQ-036 Reset mid-SEND: assert tx_reset while tx_send=1 with 3 words queued -> the next edge gives tx_send=0, tx_dados=0 and tx_count=0.
REQ-037 Timeout (macro defined, TIMEOUT_CYCLES=16): never ack -> tx_send falls after 16 SEND cycles, tx_timeout=1 stays set, and the next queued word is sent.
REQ-038 Pointer wrap: perform 20 single write/transfer pairs with FIFO_DEPTH=8 -> all 20 values are received in order, with no loss or duplication.
